// File: rtl/interconn_pkg.sv
// Shared types and helpers for the MVU interconnect and its receive endpoints.
package interconn_pkg;

    localparam int N     = 8;
    localparam int W     = 64;
    localparam int BADDR = 15;

    typedef struct packed {
        logic [BADDR-1:0] addr;
        logic [W-1:0]     word;
    } ic_word_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

endpackage

// File: rtl/interconn_rx_fifo.sv
// Small synchronous FIFO of interconnect words; extra pointer MSB separates full from empty.
module interconn_rx_fifo
    import interconn_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           push,
    input  logic           pop,
    input  ic_word_t       din,
    output ic_word_t       dout,
    output logic           full,
    output logic           empty,
    output logic [AW:0]    count
);

    logic [AW:0] wptr, rptr;
    ic_word_t    mem [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is legal only when the head leaves at the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/interconn_rx.sv
// Per-MVU receive endpoint: filters interconnect words, buffers them and drains
// them into the shared local memory write port when it is free.
module interconn_rx #(
    parameter int N     = interconn_pkg::N,
    parameter int W     = interconn_pkg::W,
    parameter int BADDR = interconn_pkg::BADDR,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             recv_en,
    input  logic [N-1:0]     recv_from,
    input  logic [BADDR-1:0] recv_addr,
    input  logic [W-1:0]     recv_word,
    input  logic [N-1:0]     src_mask,
    input  logic             mem_busy,
    output logic             mem_wr_en,
    output logic [BADDR-1:0] mem_wr_addr,
    output logic [W-1:0]     mem_wr_word,
    output logic [CW-1:0]    fifo_cnt,
    output logic             overflow,
    output logic             bad_src,
    output logic [CNTW-1:0]  drop_cnt,
    output logic [CNTW-1:0]  wr_cnt,
    input  logic             stat_clr
);

    import interconn_pkg::*;

    ic_word_t din, dout;
    logic     full, empty;
    logic     src_ok, pop, push, drop_src, drop_ovf, drop;

    assign src_ok   = is_onehot(recv_from) && ((recv_from & src_mask) != '0);
    assign pop      = ~mem_busy & ~empty;
    assign push     = recv_en & src_ok & (~full | pop);
    // A bad source wins over overflow so a word is only ever counted once.
    assign drop_src = recv_en & ~src_ok;
    assign drop_ovf = recv_en & src_ok & full & ~pop;
    assign drop     = drop_src | drop_ovf;
    assign din      = '{addr: recv_addr, word: recv_word};

    interconn_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_word <= '0;
        end else begin
            mem_wr_en <= pop;
            if (pop) begin
                mem_wr_addr <= dout.addr;
                mem_wr_word <= dout.word;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            overflow <= 1'b0;
            bad_src  <= 1'b0;
            drop_cnt <= '0;
            wr_cnt   <= '0;
        end else if (stat_clr) begin
            overflow <= 1'b0;
            bad_src  <= 1'b0;
            drop_cnt <= '0;
            wr_cnt   <= '0;
        end else begin
            if (drop_src) bad_src  <= 1'b1;
            if (drop_ovf) overflow <= 1'b1;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNTW'(1);
            if (pop) wr_cnt <= wr_cnt + CNTW'(1);
        end
    end

endmodule
